// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register and its command sequencer.
// Mode encoding doubles as the command opcode, with 2'b11 meaning READ.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        SR_SHL  = 2'b00,
        SR_SHR  = 2'b01,
        SR_LOAD = 2'b10,
        SR_HOLD = 2'b11
    } sr_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } ctrl_state_e;

    function automatic logic is_shift(sr_mode_e op);
        return (op == SR_SHL) || (op == SR_SHR);
    endfunction

endpackage

// File: rtl/shift_reg_ctrl_if.sv
// Command and response handshake bundle between requester and sequencer.
interface shift_reg_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/shift_register.sv
// 4-operation universal shift register; zeros shift in from either end.
module shift_register
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        unique case (sr_mode_e'(mode))
            SR_SHL:  q_d = {q_q[WIDTH-2:0], 1'b0};
            SR_SHR:  q_d = {1'b0, q_q[WIDTH-1:1]};
            SR_LOAD: q_d = data_in;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign data_out = q_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Sequencer: accepts one command, drives the shift register for the
// required cycles, then presents the frozen register contents.
module shift_reg_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    shift_reg_ctrl_if.slave  bus,
    output logic             busy,
    output logic             sr_rst,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic [WIDTH-1:0] sr_data_out
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sr_mode_e         op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    sr_mode_e         mode;
    sr_mode_e         cmd_op_e;

    assign cmd_op_e = sr_mode_e'(bus.cmd_op);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d   = cmd_op_e;
                    data_d = bus.cmd_data;
                    cnt_d  = '0;
                    if (cmd_op_e == SR_LOAD) begin
                        cnt_d   = CNT_W'(1);
                        state_d = RUN;
                    end else if (is_shift(cmd_op_e) && bus.cmd_count != '0) begin
                        cnt_d   = bus.cmd_count;
                        state_d = RUN;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= SR_HOLD;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    // Only RUN moves the register; every other state holds it frozen.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        mode          = SR_HOLD;
        sr_data_in    = '0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
            end
            RUN: begin
                mode = op_q;
                if (op_q == SR_LOAD) sr_data_in = data_q;
            end
            RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign sr_mode      = mode;
    assign sr_rst       = ~rst;
    assign bus.rsp_data = sr_data_out;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench: sequencer plus register against an arithmetic model.
module tb_shift_reg_ctrl;
    import shift_reg_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    shift_reg_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic             busy;
    logic             sr_rst;
    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_data_in;
    logic [WIDTH-1:0] sr_data_out;

    shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .rst         (rst),
        .bus         (bus.slave),
        .busy        (busy),
        .sr_rst      (sr_rst),
        .sr_mode     (sr_mode),
        .sr_data_in  (sr_data_in),
        .sr_data_out (sr_data_out)
    );

    shift_register #(.WIDTH(WIDTH)) u_sr (
        .clock    (clock),
        .rst      (sr_rst),
        .mode     (sr_mode),
        .data_in  (sr_data_in),
        .data_out (sr_data_out)
    );

    int checks = 0;
    int errors = 0;
    int model  = 0;

    function automatic int model_next(int v, logic [1:0] op, int cnt, int data);
        case (op)
            2'b00:   return (v << cnt) & MASK;
            2'b01:   return v >> cnt;
            2'b10:   return data & MASK;
            default: return v;
        endcase
    endfunction

    function automatic int exp_lat(logic [1:0] op, int cnt);
        if (op == 2'b10) return 2;
        if (op[1] == 1'b0 && cnt > 0) return cnt + 1;
        return 1;
    endfunction

    function automatic int exp_mode_cycles(logic [1:0] op, int cnt);
        if (op == 2'b10) return 1;
        if (op[1] == 1'b0) return cnt;
        return 0;
    endfunction

    // Call at a negedge; returns at the negedge where rsp_valid is first seen.
    task automatic run_cmd(input logic [1:0] op, input int cnt, input int data,
                           output int lat, output int mode_n, output int busy_n,
                           output int wait_n, output int bad_din, output bit tmo);
        int k;
        lat = 0; mode_n = 0; busy_n = 0; wait_n = 0; bad_din = 0; tmo = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_count = CNT_W'(cnt);
        bus.cmd_data  = WIDTH'(data);
        while (!bus.cmd_ready && wait_n < 50) begin
            @(negedge clock);
            wait_n++;
        end
        if (!bus.cmd_ready) begin
            tmo = 1'b1;
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (busy) busy_n++;
            if (op != 2'b11 && sr_mode == op) mode_n++;
            if (sr_mode == 2'b10 && sr_data_in !== WIDTH'(data)) bad_din++;
        end while (!bus.rsp_valid && k < 40);
        if (!bus.rsp_valid) tmo = 1'b1;
        lat = k;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_count = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (sr_rst !== 1'b1 || sr_data_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_sr: sr_rst=%b reg=%h want 1/0", sr_rst, sr_data_out);
        end
        rst = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            sr_mode !== 2'b11 || sr_data_in !== 4'h0 || sr_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: rdy=%b busy=%b rv=%b mode=%b din=%h srr=%b want 1 0 0 11 0 0",
                     bus.cmd_ready, busy, bus.rsp_valid, sr_mode, sr_data_in, sr_rst);
        end
        model = 0;
    endtask

    task automatic do_and_check(input string name, input logic [1:0] op,
                                input int cnt, input int data, input int want_busy);
        int lat, mn, bn, wn, bd, exp;
        bit tmo;
        run_cmd(op, cnt, data, lat, mn, bn, wn, bd, tmo);
        model = model_next(model, op, cnt, data);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL %s_timeout: no handshake within bound", name);
        end
        checks++;
        if (lat != exp_lat(op, cnt)) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat(op, cnt));
        end
        checks++;
        if (bus.rsp_data !== WIDTH'(model)) begin
            errors++;
            $display("FAIL %s_data: got %h want %h", name, bus.rsp_data, WIDTH'(model));
        end
        exp = exp_mode_cycles(op, cnt);
        checks++;
        if (op != 2'b11 && mn != exp) begin
            errors++;
            $display("FAIL %s_mode_cycles: got %0d want %0d", name, mn, exp);
        end
        checks++;
        if (sr_mode !== 2'b11 || bd != 0 || wn != 0) begin
            errors++;
            $display("FAIL %s_resp_state: mode=%b bad_din=%0d wait=%0d want 11 0 0",
                     name, sr_mode, bd, wn);
        end
        if (want_busy >= 0) begin
            checks++;
            if (bn != want_busy) begin
                errors++;
                $display("FAIL %s_busy: got %0d want %0d", name, bn, want_busy);
            end
        end
        finish_rsp();
    endtask

    task automatic test_load();
        do_and_check("load", 2'b10, 0, 4'b1011, 2);
    endtask

    task automatic test_shl();
        do_and_check("shl1", 2'b00, 1, 0, 2);
        do_and_check("reload", 2'b10, 0, 4'b1011, -1);
        do_and_check("shl3", 2'b00, 3, 0, 4);
    endtask

    task automatic test_shr();
        do_and_check("reload", 2'b10, 0, 4'b1011, -1);
        do_and_check("shr2", 2'b01, 2, 0, 3);
        do_and_check("reload", 2'b10, 0, 4'b1011, -1);
        do_and_check("shr6", 2'b01, 6, 0, 7);
    endtask

    task automatic test_count_zero();
        do_and_check("reload", 2'b10, 0, 4'b0101, -1);
        do_and_check("shl0", 2'b00, 0, 0, 1);
        do_and_check("read", 2'b11, 9, 0, 1);
    endtask

    task automatic test_rsp_hold();
        int lat, mn, bn, wn, bd;
        bit tmo;
        do_and_check("reload", 2'b10, 0, 4'b1110, -1);
        run_cmd(2'b01, 1, 0, lat, mn, bn, wn, bd, tmo);
        model = model_next(model, 2'b01, 1, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_data  = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== WIDTH'(model) ||
                bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: rv=%b data=%h rdy=%b want 1 %h 0",
                         i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, WIDTH'(model));
            end
        end
        bus.cmd_valid = 1'b0;
        finish_rsp();
        checks++;
        if (busy !== 1'b0 || sr_data_out !== WIDTH'(model)) begin
            errors++;
            $display("FAIL hold_ignored_cmd: busy=%b reg=%h want 0 %h",
                     busy, sr_data_out, WIDTH'(model));
        end
    endtask

    task automatic test_reset_mid_run();
        do_and_check("reload", 2'b10, 0, 4'b1011, -1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_count = CNT_W'(5);
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        #1;
        checks++;
        if (sr_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst_sr_rst: got %b want 1", sr_rst);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || sr_data_out !== 4'h0) begin
            errors++;
            $display("FAIL midrst_state: busy=%b rv=%b reg=%h want 0 0 0",
                     busy, bus.rsp_valid, sr_data_out);
        end
        rst = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: rdy=%b rv=%b want 1 0", bus.cmd_ready, bus.rsp_valid);
        end
        model = 0;
    endtask

    task automatic test_back_to_back();
        do_and_check("b2b_load", 2'b10, 0, 4'b0011, 2);
        do_and_check("b2b_shl", 2'b00, 2, 0, 3);
        do_and_check("b2b_read", 2'b11, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            int cnt, data, gap;
            op   = 2'($urandom_range(0, 3));
            cnt  = $urandom_range(0, 15);
            data = $urandom_range(0, MASK);
            gap  = $urandom_range(0, 2);
            do_and_check("rand", op, cnt, data, -1);
            repeat (gap) @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_shr();
        test_count_zero();
        test_rsp_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
